// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: pipeline-register fields in, hazard/forward controls out
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5,
    parameter int NUM_RS = 2,
    parameter int CNT_W  = 16
);
    logic                     IFID_valid;
    logic [NUM_RS*REG_AW-1:0] IFID_rs;
    logic [REG_AW-1:0]        IFID_rd;
    logic                     IFID_RegWrite;
    logic [NUM_RS*REG_AW-1:0] IDEX_rs;
    logic [REG_AW-1:0]        IDEX_rd;
    logic                     IDEX_MemRead;
    logic                     IDEX_is_md;
    logic [REG_AW-1:0]        EXMEM_rd;
    logic                     EXMEM_RegWrite;
    logic [REG_AW-1:0]        MEMWB_rd;
    logic                     MEMWB_RegWrite;
    logic [NUM_RS*2-1:0]      ForwardSel;
    logic                     stall;
    logic                     flush_idex;
    logic                     ex_hold;
    logic                     md_busy;
    logic                     md_done;
    logic [REG_AW-1:0]        md_rd;
    logic [CNT_W-1:0]         stall_cycles;

    modport master (
        output IFID_valid, IFID_rs, IFID_rd, IFID_RegWrite, IDEX_rs, IDEX_rd, IDEX_MemRead,
               IDEX_is_md, EXMEM_rd, EXMEM_RegWrite, MEMWB_rd, MEMWB_RegWrite,
        input  ForwardSel, stall, flush_idex, ex_hold, md_busy, md_done, md_rd, stall_cycles
    );
    modport slave (
        input  IFID_valid, IFID_rs, IFID_rd, IFID_RegWrite, IDEX_rs, IDEX_rd, IDEX_MemRead,
               IDEX_is_md, EXMEM_rd, EXMEM_RegWrite, MEMWB_rd, MEMWB_RegWrite,
        output ForwardSel, stall, flush_idex, ex_hold, md_busy, md_done, md_rd, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: ALU forwarding, load-use and multi-cycle hazard control, stall counter
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int NUM_RS = 2,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    hazard_forward_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [REG_AW-1:0] md_rd_q;
    logic [CNT_W-1:0]  sc_q;
    logic [NUM_RS*2-1:0] fwd;
    logic              lu_hit, raw_hit, waw_hit, dep, struct_h, issue, stall_i;

    always_comb begin
        fwd = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            fwd[2*i +: 2] =
                (bus.EXMEM_RegWrite && bus.EXMEM_rd != '0 && bus.EXMEM_rd == bus.IDEX_rs[i*REG_AW +: REG_AW]) ? 2'b10 :
                (bus.MEMWB_RegWrite && bus.MEMWB_rd != '0 && bus.MEMWB_rd == bus.IDEX_rs[i*REG_AW +: REG_AW]) ? 2'b01 : 2'b00;
        end
    end

    always_comb begin
        lu_hit  = 1'b0;
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            lu_hit  = lu_hit  | (bus.IFID_rs[i*REG_AW +: REG_AW] == bus.IDEX_rd);
            raw_hit = raw_hit | (bus.IFID_rs[i*REG_AW +: REG_AW] == md_rd_q);
        end
    end

    // MD checks cover DONE too, so a dependent instruction reads the written-back value in IDLE
    assign waw_hit  = bus.IFID_RegWrite && bus.IFID_rd == md_rd_q;
    assign dep      = bus.IFID_valid &&
                      ((bus.IDEX_MemRead && bus.IDEX_rd != '0 && lu_hit) ||
                       (state != IDLE && md_rd_q != '0 && (raw_hit || waw_hit)));
    assign struct_h = bus.IDEX_is_md && state == BUSY;
    assign issue    = bus.IDEX_is_md && state != BUSY;
    assign stall_i  = dep || struct_h;

    // Loading MD_LAT-2 makes DONE land exactly MD_LAT cycles after the issue cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == BUSY) begin
            state_n = cnt == 8'd0 ? DONE : BUSY;
            cnt_n   = cnt == 8'd0 ? cnt : cnt - 8'd1;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
        if (issue) begin
            state_n = BUSY;
            cnt_n   = 8'(MD_LAT - 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            md_rd_q <= '0;
            sc_q    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (issue) md_rd_q <= bus.IDEX_rd;
            if (stall_i && sc_q != '1) sc_q <= sc_q + CNT_W'(1);
        end
    end

    assign bus.ForwardSel   = fwd;
    assign bus.stall        = stall_i;
    assign bus.flush_idex   = dep && !struct_h;
    assign bus.ex_hold      = struct_h;
    assign bus.md_busy      = state != IDLE;
    assign bus.md_done      = state == DONE;
    assign bus.md_rd        = md_rd_q;
    assign bus.stall_cycles = sc_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed stimulus with a cycle-level reference model and literal checks
module tb_hazard_forward_unit;
    localparam int MD_LAT = 4;
    localparam int CW     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    hazard_forward_unit_if #(.REG_AW(5), .NUM_RS(2), .CNT_W(CW)) bus ();
    hazard_forward_unit #(.REG_AW(5), .NUM_RS(2), .MD_LAT(MD_LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (bus.EXMEM_RegWrite && bus.EXMEM_rd != 0 && bus.EXMEM_rd == rs) return 2'b10;
        if (bus.MEMWB_RegWrite && bus.MEMWB_rd != 0 && bus.MEMWB_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Model: MD op is described by its issue cycle; busy for MD_LAT cycles after it, done on the last
    int         cyc = 0;
    int         iss_c = -1;
    logic [4:0] m_rd = 0;
    int         m_sc = 0;
    bit         armed = 0;

    always @(negedge clk) begin
        int age;
        logic busy_e, in_busy, lu, mdh, sh, dep, st;
        logic [4:0] r0, r1;
        age     = cyc - iss_c;
        busy_e  = iss_c >= 0 && age >= 1 && age <= MD_LAT;
        in_busy = busy_e && age < MD_LAT;
        r0      = bus.IFID_rs[4:0];
        r1      = bus.IFID_rs[9:5];
        lu      = bus.IDEX_MemRead && bus.IDEX_rd != 0 && (r0 == bus.IDEX_rd || r1 == bus.IDEX_rd);
        mdh     = busy_e && m_rd != 0 && (r0 == m_rd || r1 == m_rd || (bus.IFID_RegWrite && bus.IFID_rd == m_rd));
        sh      = bus.IDEX_is_md && in_busy;
        dep     = bus.IFID_valid && (lu || mdh);
        st      = sh || dep;
        if (armed) begin
            chk("m_fwd", 32'(bus.ForwardSel), 32'({fwd_of(bus.IDEX_rs[9:5]), fwd_of(bus.IDEX_rs[4:0])}));
            chk("m_stall", 32'(bus.stall), 32'(st));
            chk("m_flush", 32'(bus.flush_idex), 32'(dep && !sh));
            chk("m_hold", 32'(bus.ex_hold), 32'(sh));
            chk("m_busy", 32'(bus.md_busy), 32'(busy_e));
            chk("m_done", 32'(bus.md_done), 32'(busy_e && age == MD_LAT));
            chk("m_rd", 32'(bus.md_rd), 32'(m_rd));
            chk("m_sc", 32'(bus.stall_cycles), 32'(m_sc));
        end
        if (rst) begin
            iss_c = -1;
            m_rd  = 0;
            m_sc  = 0;
            armed = 1;
        end else begin
            if (bus.IDEX_is_md && !in_busy) begin
                iss_c = cyc;
                m_rd  = bus.IDEX_rd;
            end
            if (st && m_sc < (1 << CW) - 1) m_sc++;
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.IFID_valid = 0; bus.IFID_rs = 0; bus.IFID_rd = 0; bus.IFID_RegWrite = 0;
        bus.IDEX_rs = 0; bus.IDEX_rd = 0; bus.IDEX_MemRead = 0; bus.IDEX_is_md = 0;
        bus.EXMEM_rd = 0; bus.EXMEM_RegWrite = 0; bus.MEMWB_rd = 0; bus.MEMWB_RegWrite = 0;
    endtask

    initial begin
        clear();
        tick(2);
        rst = 0;
        tick(1);
        chk("rst_busy", 32'(bus.md_busy), 0);
        chk("rst_done", 32'(bus.md_done), 0);
        chk("rst_rd", 32'(bus.md_rd), 0);
        chk("rst_sc", 32'(bus.stall_cycles), 0);

        bus.EXMEM_rd = 5; bus.EXMEM_RegWrite = 1; bus.MEMWB_rd = 5; bus.MEMWB_RegWrite = 1;
        bus.IDEX_rs = {5'd6, 5'd5};
        #1 chk("fwd_ex_prio", 32'(bus.ForwardSel), 32'b0010);
        bus.EXMEM_RegWrite = 0;
        #1 chk("fwd_wb", 32'(bus.ForwardSel), 32'b0001);
        bus.EXMEM_RegWrite = 1; bus.MEMWB_rd = 6;
        #1 chk("fwd_split", 32'(bus.ForwardSel), 32'b0110);
        bus.EXMEM_rd = 0; bus.MEMWB_rd = 0; bus.IDEX_rs = 0;
        #1 chk("fwd_x0", 32'(bus.ForwardSel), 32'b0000);
        tick(1);

        clear();
        bus.IDEX_MemRead = 1; bus.IDEX_rd = 7; bus.IFID_rs = {5'd7, 5'd1}; bus.IFID_valid = 1;
        #1 chk("lu_stall", 32'(bus.stall), 1);
        chk("lu_flush", 32'(bus.flush_idex), 1);
        tick(1);
        bus.IDEX_MemRead = 0;
        #1 chk("lu_release", 32'(bus.stall), 0);
        tick(1);
        bus.IDEX_MemRead = 1; bus.IFID_valid = 0;
        #1 chk("lu_invalid", 32'(bus.stall), 0);
        tick(1);
        chk("sc_one", 32'(bus.stall_cycles), 1);

        clear();
        bus.IDEX_is_md = 1; bus.IDEX_rd = 9;
        tick(1);
        clear();
        bus.IFID_valid = 1; bus.IFID_rs = {5'd0, 5'd9};
        for (int k = 1; k <= 5; k++) begin
            #1 chk("md_busy_t", 32'(bus.md_busy), 32'(k <= 4));
            chk("md_done_t", 32'(bus.md_done), 32'(k == 4));
            chk("md_raw_stall", 32'(bus.stall), 32'(k <= 4));
            tick(1);
        end

        clear();
        bus.IDEX_is_md = 1; bus.IDEX_rd = 10;
        tick(1);
        bus.IDEX_rd = 11;
        for (int k = 1; k <= 3; k++) begin
            #1 chk("sh_hold", 32'(bus.ex_hold), 1);
            chk("sh_stall", 32'(bus.stall), 1);
            chk("sh_flush", 32'(bus.flush_idex), 0);
            tick(1);
        end
        #1 chk("sh_done", 32'(bus.md_done), 1);
        chk("sh_hold_off", 32'(bus.ex_hold), 0);
        chk("sh_rd_old", 32'(bus.md_rd), 10);
        tick(1);
        clear();
        #1 chk("b2b_rd", 32'(bus.md_rd), 11);
        chk("b2b_busy", 32'(bus.md_busy), 1);
        bus.IFID_valid = 1; bus.IFID_rs = {5'd0, 5'd11}; bus.IDEX_MemRead = 1; bus.IDEX_rd = 11;
        #1 chk("lu_md_stall", 32'(bus.stall), 1);
        chk("lu_md_flush", 32'(bus.flush_idex), 1);
        tick(1);
        clear();
        bus.IFID_valid = 1; bus.IFID_RegWrite = 1; bus.IFID_rd = 11;
        #1 chk("waw_stall", 32'(bus.stall), 1);
        tick(1);
        clear();
        tick(3);

        bus.IDEX_is_md = 1; bus.IDEX_rd = 12;
        tick(1);
        clear();
        tick(1);
        rst = 1;
        tick(1);
        rst = 0;
        #1 chk("rst_md_busy", 32'(bus.md_busy), 0);
        chk("rst_md_sc", 32'(bus.stall_cycles), 0);
        chk("rst_md_rd", 32'(bus.md_rd), 0);
        tick(5);

        bus.IDEX_MemRead = 1; bus.IDEX_rd = 7; bus.IFID_rs = {5'd0, 5'd7}; bus.IFID_valid = 1;
        tick(19);
        chk("sc_sat", 32'(bus.stall_cycles), 15);
        clear();
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
